// File: rtl/shift_add_mult_pkg.sv
// Shared types and defaults for the time-shared shift-and-add multiplier.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package shift_add_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_M    = 4;
  localparam int DEF_N    = 4;
  localparam int DEF_NREQ = 4;

  // Index width for n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_add_mult_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted req at or after ptr, wrapping upward.
// Latency: purely combinational, zero cycles.
// Backpressure: en low forces no grant; the pointer is owned by the parent.
module rr_arbiter
  import shift_add_mult_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic found;
  int   idx;

  // Scan from ptr upward with wrap; the first asserted request wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_add_mult_sched.sv
// Time-shared unsigned shift-and-add multiplier serving NREQ requesters round-robin.
// Latency: result valid exactly N edges after the accept edge; issue interval N+2.
// Backpressure: DONE holds the result until rsp_ready; no accepts while busy.
module shift_add_mult_sched
  import shift_add_mult_pkg::*;
#(
  parameter int M    = DEF_M,
  parameter int N    = DEF_N,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*M-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [M+N-1:0]    rsp_p,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam int CW = id_width(N);

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id;
  logic [M+N-1:0]  a_sh;
  logic [N-1:0]    b_sh;
  logic [M+N-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            accept;
  logic            last_iter;

  // Arbitration is only enabled in IDLE, so req_ready never depends on rsp_ready.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (state_q == IDLE),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign accept    = |gnt;
  assign last_iter = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and outputs; the result is only presented while in DONE.
  always_comb begin
    state_d   = state_q;
    req_ready = gnt;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_p     = '0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (last_iter) state_d = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = id;
        rsp_p     = acc;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, then one multiplier bit per edge for exactly N edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      id   <= '0;
    end else if (state_q == IDLE && accept) begin
      a_sh <= {{N{1'b0}}, req_a[int'(gnt_id)*M +: M]};
      b_sh <= req_b[int'(gnt_id)*N +: N];
      acc  <= '0;
      cnt  <= '0;
      id   <= gnt_id;
    end else if (state_q == BUSY) begin
      if (b_sh[0]) acc <= acc + a_sh;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
    end
  end

  // Served requester drops to lowest priority once its result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (state_q == DONE && rsp_ready) begin
      ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
    end
  end

endmodule

// File: tb/tb_shift_add_mult_sched.sv
// Directed bench for shift_add_mult_sched with hand-computed products.
// Latency: checks result arrives exactly 4 edges after accept.
// Backpressure: holds rsp_ready low in DONE and checks outputs stay frozen.
module tb_shift_add_mult_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_p;
  logic        rsp_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  shift_add_mult_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the response, checking latency from the accept edge.
  task automatic wait_rsp(input int id, input int p);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_p", 32'(rsp_p), 32'(p));
    chk("busy_done", 32'(busy), 32'd1);
    if (rsp_ready) begin
      tick();
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
    end
  endtask

  // Single request from one requester, run to completion.
  task automatic run_op(input int id, input int a, input int b);
    req_a[id*4 +: 4] = 4'(a);
    req_b[id*4 +: 4] = 4'(b);
    req_valid[id] = 1'b1;
    #1;
    chk("grant_onehot", 32'(req_ready), 32'(1 << id));
    tick();
    req_valid[id] = 1'b0;
    #1;
    chk("ready_low_busy", 32'(req_ready), 32'd0);
    wait_rsp(id, a * b);
  endtask

  initial begin
    int gnt_who [5];
    int gnt_cyc [5];
    int ng;
    int cyc;
    int ea [4];
    int eb [4];

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_p", 32'(rsp_p), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request and extremes.
    run_op(2, 13, 11);   // 143, ptr -> 3
    run_op(0, 15, 15);   // 225
    run_op(0, 0, 9);     // 0
    run_op(0, 7, 0);     // 0

    // Pointer wrap: serve 3 (ptr -> 0), then 1 (ptr -> 2), then 1|2 must pick 2.
    run_op(3, 5, 3);
    run_op(1, 6, 2);
    req_a[4 +: 4] = 4'd2;  req_b[4 +: 4] = 4'd3;
    req_a[8 +: 4] = 4'd9;  req_b[8 +: 4] = 4'd7;
    req_valid = 4'b0110;
    #1;
    chk("ptr_after_wrap", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    wait_rsp(2, 63);     // ptr -> 3

    // Back-pressure: hold rsp_ready low with requester 0 also waiting.
    rsp_ready = 1'b0;
    req_a[4 +: 4] = 4'd9;  req_b[4 +: 4] = 4'd6;
    req_valid = 4'b0010;
    #1;
    chk("bp_grant", 32'(req_ready), 32'b0010);
    tick();
    req_a[0 +: 4] = 4'd4;  req_b[0 +: 4] = 4'd4;
    req_valid = 4'b0001;
    wait_rsp(1, 54);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_p", 32'(rsp_p), 32'd54);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_no_comb_path", 32'(req_ready), 32'd0);
    tick();
    chk("bp_release_idle", 32'(rsp_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    wait_rsp(0, 16);

    // Reset during the second compute cycle.
    req_a[8 +: 4] = 4'd3;  req_b[8 +: 4] = 4'd5;
    req_valid = 4'b0100;
    tick();              // accept edge
    req_valid = '0;
    tick();              // first compute edge done; now in second compute cycle
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_p", 32'(rsp_p), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end

    // Round-robin with all requesters valid; first grant must be 0.
    for (int i = 0; i < 4; i++) begin
      ea[i] = i * 3 + 2;
      eb[i] = 15 - i * 2;
      req_a[i*4 +: 4] = 4'(ea[i]);
      req_b[i*4 +: 4] = 4'(eb[i]);
    end
    req_valid = 4'b1111;
    ng  = 0;
    cyc = 0;
    #1;
    while (ng < 5 && cyc < 60) begin
      if (req_ready != 4'b0000) begin
        gnt_who[ng] = (req_ready == 4'b0001) ? 0 : (req_ready == 4'b0010) ? 1 :
                      (req_ready == 4'b0100) ? 2 : (req_ready == 4'b1000) ? 3 : 9;
        gnt_cyc[ng] = cyc;
        ng++;
      end
      if (rsp_valid)
        chk("rr_product", 32'(rsp_p), 32'(ea[rsp_id] * eb[rsp_id]));
      if (ng < 5) begin
        tick();
        cyc++;
      end
    end
    chk("rr_grant_count", 32'(ng), 32'd5);
    tick();
    req_valid = '0;
    for (int k = 0; k < ng; k++) begin
      chk("rr_order", 32'(gnt_who[k]), 32'(k % 4));
      if (k > 0) chk("rr_interval", 32'(gnt_cyc[k] - gnt_cyc[k-1]), 32'd6);
    end
    wait_rsp(0, ea[0] * eb[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
